// File: rtl/fir_mac_engine.sv
// Streaming FIR filter: one sample in, N serial multiply-accumulates, one result out.
// Coefficients are loaded while idle; each run is framed by ap_start and a tlast sample.
module fir_mac_engine #(
    parameter int pDATA_WIDTH = 32,
    parameter int MAX_TAPS    = 32,
    parameter int TAP_IDX_W   = 5
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [TAP_IDX_W:0]     in_tap_num,
    input  logic                   in_coef_we,
    input  logic [TAP_IDX_W-1:0]   in_coef_addr,
    input  logic [pDATA_WIDTH-1:0] in_coef_wdata,
    input  logic                   in_ap_start,
    output logic                   out_ap_done,
    output logic                   out_ap_idle,
    input  logic                   in_ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] in_ss_tdata,
    input  logic                   in_ss_tlast,
    output logic                   out_ss_tready,
    output logic                   out_sm_tvalid,
    output logic [pDATA_WIDTH-1:0] out_sm_tdata,
    output logic                   out_sm_tlast,
    input  logic                   in_sm_tready
);

    typedef enum logic [1:0] {IDLE, WAIT_IN, MAC, OUT} state_e;

    localparam logic [TAP_IDX_W:0] MAX_N = (TAP_IDX_W+1)'(MAX_TAPS);

    state_e                 state_q;
    logic [pDATA_WIDTH-1:0] coef_q [MAX_TAPS];
    logic [pDATA_WIDTH-1:0] hist_q [MAX_TAPS];
    logic [pDATA_WIDTH-1:0] acc_q;
    logic [TAP_IDX_W:0]     n_q;
    logic [TAP_IDX_W:0]     idx_q;
    logic                   tlast_q;
    logic                   done_q;
    logic                   idle_q;
    logic                   ss_tready_q;
    logic                   sm_tvalid_q;
    logic [pDATA_WIDTH-1:0] sm_tdata_q;
    logic                   sm_tlast_q;

    logic [TAP_IDX_W:0]     n_d;
    logic [pDATA_WIDTH-1:0] prod;
    logic [pDATA_WIDTH-1:0] acc_d;
    logic                   mac_last;
    logic                   coef_wr_ok;

    // Tap count clamp: zero taps still produces a single-tap result.
    always_comb begin
        n_d = in_tap_num;
        if (in_tap_num == '0)
            n_d = (TAP_IDX_W+1)'(1);
        else if (in_tap_num > MAX_N)
            n_d = MAX_N;
    end

    // Low pDATA_WIDTH bits of a two's-complement product do not depend on
    // operand signedness, so a same-width multiply gives the wrapped result.
    assign prod       = coef_q[idx_q[TAP_IDX_W-1:0]] * hist_q[idx_q[TAP_IDX_W-1:0]];
    assign acc_d      = acc_q + prod;
    assign mac_last   = (idx_q == n_q - 1'b1);
    assign coef_wr_ok = in_coef_we && (state_q == IDLE) && ({1'b0, in_coef_addr} < MAX_N);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            for (int i = 0; i < MAX_TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
            acc_q       <= '0;
            n_q         <= (TAP_IDX_W+1)'(1);
            idx_q       <= '0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
        end else begin
            if (coef_wr_ok)
                coef_q[in_coef_addr] <= in_coef_wdata;

            case (state_q)
                IDLE: begin
                    if (in_ap_start) begin
                        n_q         <= n_d;
                        for (int i = 0; i < MAX_TAPS; i++)
                            hist_q[i] <= '0;
                        done_q      <= 1'b0;
                        idle_q      <= 1'b0;
                        ss_tready_q <= 1'b1;
                        state_q     <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (in_ss_tvalid && ss_tready_q) begin
                        hist_q[0] <= in_ss_tdata;
                        for (int i = 1; i < MAX_TAPS; i++)
                            hist_q[i] <= hist_q[i-1];
                        tlast_q     <= in_ss_tlast;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        ss_tready_q <= 1'b0;
                        state_q     <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (mac_last)
                        state_q <= OUT;
                end
                OUT: begin
                    // First OUT cycle registers the result; it is then held until taken.
                    if (!sm_tvalid_q) begin
                        sm_tvalid_q <= 1'b1;
                        sm_tdata_q  <= acc_q;
                        sm_tlast_q  <= tlast_q;
                    end else if (in_sm_tready) begin
                        sm_tvalid_q <= 1'b0;
                        if (tlast_q) begin
                            done_q  <= 1'b1;
                            idle_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ss_tready_q <= 1'b1;
                            state_q     <= WAIT_IN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_ap_done   = done_q;
    assign out_ap_idle   = idle_q;
    assign out_ss_tready = ss_tready_q;
    assign out_sm_tvalid = sm_tvalid_q;
    assign out_sm_tdata  = sm_tdata_q;
    assign out_sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: convolution model over the accepted samples, random
// stimulus and backpressure, plus literal golden values for the directed cases.
module tb_fir_mac_engine;
    localparam int DW = 32;
    localparam int MT = 32;
    localparam int IW = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW:0]   in_tap_num = '0;
    logic          in_coef_we = 1'b0;
    logic [IW-1:0] in_coef_addr = '0;
    logic [DW-1:0] in_coef_wdata = '0;
    logic          in_ap_start = 1'b0;
    logic          out_ap_done, out_ap_idle;
    logic          in_ss_tvalid = 1'b0;
    logic [DW-1:0] in_ss_tdata = '0;
    logic          in_ss_tlast = 1'b0;
    logic          out_ss_tready;
    logic          out_sm_tvalid;
    logic [DW-1:0] out_sm_tdata;
    logic          out_sm_tlast;
    logic          in_sm_tready = 1'b0;

    fir_mac_engine #(.pDATA_WIDTH(DW), .MAX_TAPS(MT), .TAP_IDX_W(IW)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_tap_num(in_tap_num),
        .in_coef_we(in_coef_we), .in_coef_addr(in_coef_addr), .in_coef_wdata(in_coef_wdata),
        .in_ap_start(in_ap_start), .out_ap_done(out_ap_done), .out_ap_idle(out_ap_idle),
        .in_ss_tvalid(in_ss_tvalid), .in_ss_tdata(in_ss_tdata), .in_ss_tlast(in_ss_tlast),
        .out_ss_tready(out_ss_tready), .out_sm_tvalid(out_sm_tvalid), .out_sm_tdata(out_sm_tdata),
        .out_sm_tlast(out_sm_tlast), .in_sm_tready(in_sm_tready)
    );

    always #5 aclk = ~aclk;

    int errs = 0;
    int checks = 0;

    // Model state: coefficients as the block should hold them, samples of the current run.
    int mc[MT];
    int mx[$];
    int mn = 1;
    bit mdl_idle = 1;
    int expq[$];
    bit explast[$];
    int got_q[$];
    int bp_mode = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    int IMP[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int model_y();
        int s = 0;
        for (int i = 0; i < mn; i++)
            if (i < mx.size()) s += mc[i] * mx[mx.size()-1-i];
        return s;
    endfunction

    // Output sink backpressure
    always @(posedge aclk) begin
        #1;
        case (bp_mode)
            0: in_sm_tready = 1'b1;
            1: in_sm_tready = 1'($urandom_range(0, 1));
            default: in_sm_tready = 1'b0;
        endcase
    end

    // Compare process: every result handshake against the model, hold/stall rules each cycle.
    always @(negedge aclk) begin
        int e;
        bit l;
        if (!aresetn) begin
            prev_stall = 0;
        end else begin
            if (out_sm_tvalid && prev_stall) chk("hold_data", out_sm_tdata, prev_data);
            if (out_sm_tvalid) chk("ss_tready_while_out", 32'(out_ss_tready), 32'd0);
            if (out_sm_tvalid && in_sm_tready) begin
                if (expq.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL unexpected_output: got %0h expected none", out_sm_tdata);
                end else begin
                    e = expq.pop_front();
                    l = explast.pop_front();
                    chk("y", out_sm_tdata, e);
                    chk("tlast", 32'(out_sm_tlast), 32'(l));
                    got_q.push_back(out_sm_tdata);
                end
            end
            prev_stall = out_sm_tvalid && !in_sm_tready;
            prev_data  = out_sm_tdata;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_idle"}, 32'(out_ap_idle), 32'd1);
        chk({nm, "_done"}, 32'(out_ap_done), 32'd0);
        chk({nm, "_ss_tready"}, 32'(out_ss_tready), 32'd0);
        chk({nm, "_sm_tvalid"}, 32'(out_sm_tvalid), 32'd0);
        chk({nm, "_sm_tdata"}, out_sm_tdata, 32'd0);
        chk({nm, "_sm_tlast"}, 32'(out_sm_tlast), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MT; i++) mc[i] = 0;
        mx.delete(); expq.delete(); explast.delete();
        mdl_idle = 1;
    endtask

    task automatic wr_coef(input int a, input int v);
        in_coef_we = 1'b1; in_coef_addr = IW'(a); in_coef_wdata = v;
        @(posedge aclk);
        if (mdl_idle) mc[a] = v;
        #1;
        in_coef_we = 1'b0;
    endtask

    task automatic start(input int tn);
        in_tap_num = (IW+1)'(tn); in_ap_start = 1'b1;
        @(posedge aclk);
        if (mdl_idle) begin
            mn = (tn == 0) ? 1 : (tn > MT) ? MT : tn;
            mx.delete();
            mdl_idle = 0;
        end
        #1;
        in_ap_start = 1'b0;
    endtask

    task automatic send(input int x, input bit last);
        int k = 0;
        bit ok = 0;
        in_ss_tdata = x; in_ss_tlast = last; in_ss_tvalid = 1'b1;
        while (!ok && k < 500) begin
            @(negedge aclk);
            if (out_ss_tready) ok = 1; else k++;
        end
        if (!ok) begin
            checks++; errs++;
            $display("FAIL send_timeout: got tready=0 for %0d cycles expected acceptance", k);
            in_ss_tvalid = 1'b0;
        end else begin
            @(posedge aclk);
            mx.push_back(x);
            expq.push_back(model_y());
            explast.push_back(last);
            #1;
            in_ss_tvalid = 1'b0; in_ss_tlast = 1'b0;
        end
    endtask

    task automatic drain(input bit was_last);
        int k = 0;
        while (expq.size() > 0 && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        if (expq.size() > 0) begin
            checks++; errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
        step();
        if (was_last) begin
            mdl_idle = 1;
            chk("done_after_last", 32'(out_ap_done), 32'd1);
            chk("idle_after_last", 32'(out_ap_idle), 32'd1);
        end
    endtask

    // Cycles from the accepting edge until out_sm_tvalid is seen high.
    task automatic latency(input string nm, input int exp);
        int k = 0;
        do begin
            step();
            k++;
        end while (!out_sm_tvalid && k < 200);
        chk(nm, k, exp);
    endtask

    task automatic run_impulse(input string nm);
        for (int i = 0; i < 11; i++) wr_coef(i, IMP[i]);
        got_q.delete();
        bp_mode = 0;
        start(11);
        send(1, 0);
        for (int i = 1; i <= 10; i++) send(0, i == 10);
        drain(1);
        chk({nm, "_count"}, got_q.size(), 11);
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            chk({nm, "_golden"}, got_q[i], IMP[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int x0;
        logic [DW-1:0] held;
        model_reset();
        repeat (2) step();
        chk_reset_outs("in_reset");
        aresetn = 1'b1;
        step();
        chk_reset_outs("after_reset");

        // Coefficients must come up zero after reset
        got_q.delete();
        start(1);
        send(5, 1);
        drain(1);
        chk("zero_coef_lit", got_q.size() > 0 ? got_q[0] : -1, 0);

        run_impulse("impulse");

        // Latency and backpressure, N=4
        for (int i = 0; i < 4; i++) wr_coef(i, i + 1);
        start(4);
        bp_mode = 2;
        send(7, 1);
        latency("latency_n4", 5);
        held = out_sm_tdata;
        repeat (20) begin
            step();
            chk("bp_ss_tready", 32'(out_ss_tready), 32'd0);
            chk("bp_tvalid", 32'(out_sm_tvalid), 32'd1);
        end
        chk("bp_held", out_sm_tdata, held);
        chk("bp_lit", out_sm_tdata, 32'd7);
        bp_mode = 0;
        drain(1);

        // Truncating wrap
        got_q.delete();
        wr_coef(0, 32'h4000_0000);
        start(1);
        send(4, 1);
        drain(1);
        chk("wrap_lit", got_q.size() > 0 ? got_q[0] : -1, 0);

        // Writes and start during WAIT_IN are ignored
        got_q.delete();
        wr_coef(0, 3); wr_coef(1, 5);
        start(2);
        wr_coef(0, 100);
        start(1);
        chk("guard_not_idle", 32'(out_ap_idle), 32'd0);
        chk("guard_wait_in", 32'(out_ss_tready), 32'd1);
        send(7, 0);
        send(1, 1);
        drain(1);
        chk("guard_y0_lit", got_q.size() > 0 ? got_q[0] : -1, 21);
        chk("guard_y1_lit", got_q.size() > 1 ? got_q[1] : -1, 38);

        // Tap count 0 clamps to a single tap
        got_q.delete();
        wr_coef(0, -3); wr_coef(1, 50);
        start(0);
        bp_mode = 2;
        send(9, 1);
        latency("latency_n0", 2);
        bp_mode = 0;
        drain(1);
        chk("ntap0_lit", got_q.size() > 0 ? got_q[0] : -1, -27);

        // Tap count above MAX_TAPS clamps to MAX_TAPS
        for (int i = 0; i < MT; i++) wr_coef(i, int'($urandom_range(0, 200)) - 100);
        start(40);
        bp_mode = 2;
        send(int'($urandom), 1);
        latency("latency_n40", MT + 1);
        bp_mode = 0;
        drain(1);

        // Randomized runs with random backpressure
        for (int r = 0; r < 4; r++) begin
            int n = int'($urandom_range(1, MT));
            for (int i = 0; i < MT; i++)
                wr_coef(i, (r[0]) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000);
            start(n);
            bp_mode = 1;
            for (int s = 0; s < 12; s++) begin
                x0 = (r[1]) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                send(x0, s == 11);
            end
            drain(1);
            bp_mode = 0;
        end

        // Reset in the middle of MAC drops the in-flight result
        for (int i = 0; i < 11; i++) wr_coef(i, IMP[i]);
        start(11);
        send(1, 0);
        step();
        step();
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outs("mid_mac_reset");
        model_reset();
        step();
        aresetn = 1'b1;
        step();
        chk_reset_outs("post_mid_reset");
        run_impulse("impulse_after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
